// File: rtl/io_bus_package.sv
// io_bus_package: register offsets, handshake state and response record shared by the io_bus_responder slice
package io_bus_package;
  localparam logic [7:0] OUT_OFFSET         = 8'h00;
  localparam logic [7:0] IN_OFFSET          = 8'h04;
  localparam logic [7:0] UIO_OUT_OFFSET     = 8'h08;
  localparam logic [7:0] UIO_OE_OFFSET      = 8'h0C;
  localparam logic [7:0] UIO_IN_OFFSET      = 8'h10;
  localparam logic [7:0] EDGE_STATUS_OFFSET = 8'h14;
  localparam logic [7:0] EDGE_MASK_OFFSET   = 8'h18;
  typedef enum logic {IDLE, RESPOND} state_t;
  typedef struct packed {
    logic [31:0] read_data;
    logic        error;
  } response_t;
endpackage

// File: rtl/io_bus_responder_if.sv
// io_bus_responder_if: cpu data bus (request valid/ready/write/address/data/strobe, response valid/ready/data/error); master=cpu, slave=responder
interface io_bus_responder_if #(parameter int ADDRESS_WIDTH = 5);
  logic                     request_valid;
  logic                     request_ready;
  logic                     request_write;
  logic [ADDRESS_WIDTH-1:0] request_address;
  logic [31:0]              request_write_data;
  logic [3:0]               request_strobe;
  logic                     response_valid;
  logic                     response_ready;
  logic [31:0]              response_read_data;
  logic                     response_error;
  modport master(
    output request_valid, request_write, request_address, request_write_data, request_strobe, response_ready,
    input  request_ready, response_valid, response_read_data, response_error
  );
  modport slave(
    input  request_valid, request_write, request_address, request_write_data, request_strobe, response_ready,
    output request_ready, response_valid, response_read_data, response_error
  );
endinterface

// File: rtl/input_synchroniser.sv
// input_synchroniser: STAGES-deep reset-to-zero flop chain; clock/reset, d (async input), q (synchronised output)
module input_synchroniser #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] flops;
  always_ff @(posedge clock)
    if (reset) flops <= '0;
    else flops <= {flops[STAGES-2:0], d};
  assign q = flops[STAGES-1];
endmodule

// File: rtl/io_bus_responder.sv
// io_bus_responder: memory-mapped pin register file on the cpu bus; clock/reset, bus (slave), ui_in/uo_out, uio_in/uio_out/uio_oe, irq=|(edge_status&edge_mask)
module io_bus_responder
  import io_bus_package::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  io_bus_responder_if.slave        bus,
  input  logic [7:0]               ui_in,
  output logic [7:0]               uo_out,
  input  logic [7:0]               uio_in,
  output logic [7:0]               uio_out,
  output logic [7:0]               uio_oe,
  output logic                     irq
);
  state_t state, state_next;
  response_t response, response_next;
  logic [7:0] ui_sync, uio_sync, ui_prev, edge_status, edge_mask, read_value, status_clear;
  logic hit_out, hit_in, hit_uio_out, hit_uio_oe, hit_uio_in, hit_status, hit_mask;
  logic accept, do_write, unused_bits;
  function automatic logic hit(input logic [ADDRESS_WIDTH-1:0] address, input logic [7:0] offset);
    return address == ADDRESS_WIDTH'(offset);
  endfunction
  input_synchroniser #(.WIDTH(8), .STAGES(SYNC_STAGES)) ui_synchroniser (
    .clock(clock), .reset(reset), .d(ui_in), .q(ui_sync)
  );
  input_synchroniser #(.WIDTH(8), .STAGES(SYNC_STAGES)) uio_synchroniser (
    .clock(clock), .reset(reset), .d(uio_in), .q(uio_sync)
  );
  assign hit_out     = hit(bus.request_address, OUT_OFFSET);
  assign hit_in      = hit(bus.request_address, IN_OFFSET);
  assign hit_uio_out = hit(bus.request_address, UIO_OUT_OFFSET);
  assign hit_uio_oe  = hit(bus.request_address, UIO_OE_OFFSET);
  assign hit_uio_in  = hit(bus.request_address, UIO_IN_OFFSET);
  assign hit_status  = hit(bus.request_address, EDGE_STATUS_OFFSET);
  assign hit_mask    = hit(bus.request_address, EDGE_MASK_OFFSET);
  assign accept   = bus.request_valid & bus.request_ready;
  assign do_write = accept & bus.request_write & bus.request_strobe[0];
  assign status_clear = (do_write & hit_status) ? bus.request_write_data[7:0] : 8'h00;
  assign read_value = hit_out ? uo_out : hit_in ? ui_sync : hit_uio_out ? uio_out : hit_uio_oe ? uio_oe :
                      hit_uio_in ? uio_sync : hit_status ? edge_status : hit_mask ? edge_mask : 8'h00;
  // misaligned addresses never match an offset, so "no hit" covers both error cases
  assign response_next = '{
    read_data: bus.request_write ? 32'h0 : {24'h0, read_value},
    error:     ~(hit_out | hit_in | hit_uio_out | hit_uio_oe | hit_uio_in | hit_status | hit_mask)
  };
  always_comb begin
    state_next = state;
    bus.request_ready = state == IDLE;
    bus.response_valid = state == RESPOND;
    if (state == IDLE && bus.request_valid) state_next = RESPOND;
    else if (state == RESPOND && bus.response_ready) state_next = IDLE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      response <= '0;
      uo_out <= '0;
      uio_out <= '0;
      uio_oe <= '0;
      edge_mask <= '0;
      edge_status <= '0;
      ui_prev <= '0;
    end else begin
      state <= state_next;
      if (accept) response <= response_next;
      if (do_write & hit_out) uo_out <= bus.request_write_data[7:0];
      if (do_write & hit_uio_out) uio_out <= bus.request_write_data[7:0];
      if (do_write & hit_uio_oe) uio_oe <= bus.request_write_data[7:0];
      if (do_write & hit_mask) edge_mask <= bus.request_write_data[7:0];
      ui_prev <= ui_sync;
      edge_status <= (edge_status & ~status_clear) | (ui_sync & ~ui_prev);
    end
  assign bus.response_read_data = response.read_data;
  assign bus.response_error = response.error;
  assign irq = |(edge_status & edge_mask);
  assign unused_bits = ^{bus.request_write_data[31:8], bus.request_strobe[3:1]};
endmodule

// File: tb/tb_io_bus_responder.sv
// tb_io_bus_responder: directed table, corner sequences and randomized traffic against a delay-line register model
module tb_io_bus_responder;
  localparam int S = 2;
  logic clk = 0, rst = 1, chk_on = 0;
  logic [7:0] ui_in = 0, uio_in = 0;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic irq;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  io_bus_responder_if #(.ADDRESS_WIDTH(5)) bus();
  io_bus_responder #(.ADDRESS_WIDTH(5), .SYNC_STAGES(S)) dut (
    .clock(clk), .reset(rst), .bus(bus), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .irq(irq)
  );
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction
  logic [7:0] m_reg [8];
  logic [7:0] m_status;
  logic [7:0] ui_q[$], uio_q[$];
  logic m_busy;
  logic [31:0] m_rd;
  logic m_err;
  initial forever begin
    logic [7:0] clr, rise, v;
    int idx;
    logic e;
    @(posedge clk);
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = 8'h00;
      m_status = 0; m_busy = 0; m_rd = 0; m_err = 0;
      ui_q = {}; uio_q = {};
      repeat (S + 1) begin ui_q.push_back(8'h00); uio_q.push_back(8'h00); end
    end else begin
      clr = 0;
      rise = ui_q[S-1] & ~ui_q[S];
      if (!m_busy && bus.request_valid) begin
        idx = int'(bus.request_address[4:2]);
        e = bus.request_address[1:0] != 0 || idx == 7;
        v = idx == 1 ? ui_q[S-1] : idx == 4 ? uio_q[S-1] : idx == 5 ? m_status : m_reg[idx];
        m_rd = (e || bus.request_write) ? 32'h0 : {24'h0, v};
        m_err = e;
        if (bus.request_write && bus.request_strobe[0] && !e) begin
          if (idx == 5) clr = bus.request_write_data[7:0];
          else if (idx == 0 || idx == 2 || idx == 3 || idx == 6) m_reg[idx] = bus.request_write_data[7:0];
        end
        m_busy = 1;
      end else if (m_busy && bus.response_ready) m_busy = 0;
      m_status = (m_status & ~clr) | rise;
      ui_q.push_front(ui_in); void'(ui_q.pop_back());
      uio_q.push_front(uio_in); void'(uio_q.pop_back());
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst && chk_on) begin
      check("model uo_out", uo_out, m_reg[0]);
      check("model uio_out", uio_out, m_reg[2]);
      check("model uio_oe", uio_oe, m_reg[3]);
      check("model irq", irq, |(m_status & m_reg[6]));
      check("model request_ready", bus.request_ready, !m_busy);
      check("model response_valid", bus.response_valid, m_busy);
      if (m_busy) begin
        check("model read_data", bus.response_read_data, m_rd);
        check("model error", bus.response_error, m_err);
      end
    end
  end
  task automatic txn(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int stall, output logic [31:0] rd, output logic er);
    bus.request_valid = 1; bus.request_write = w; bus.request_address = a;
    bus.request_write_data = d; bus.request_strobe = s; bus.response_ready = 0;
    @(negedge clk);
    bus.request_valid = 0;
    check("response latency", bus.response_valid, 1'b1);
    repeat (stall) @(negedge clk);
    rd = bus.response_read_data; er = bus.response_error;
    bus.response_ready = 1;
    @(negedge clk);
    bus.response_ready = 0;
  endtask
  typedef struct {
    logic w; logic [4:0] a; logic [31:0] d; logic [3:0] s; logic [31:0] rd; logic er;
  } vec_t;
  vec_t vt[$];
  initial begin
    logic [31:0] rd, held;
    logic er;
    bus.request_valid = 0; bus.request_write = 0; bus.request_address = 0;
    bus.request_write_data = 0; bus.request_strobe = 0; bus.response_ready = 0;
    vt.push_back('{1'b1, 5'h00, 32'hA5, 4'b0001, 32'h0, 1'b0});
    vt.push_back('{1'b0, 5'h00, 32'h0, 4'b0000, 32'hA5, 1'b0});
    vt.push_back('{1'b1, 5'h00, 32'h5A, 4'b0010, 32'h0, 1'b0});
    vt.push_back('{1'b0, 5'h00, 32'h0, 4'b1111, 32'hA5, 1'b0});
    vt.push_back('{1'b1, 5'h08, 32'h33, 4'b0001, 32'h0, 1'b0});
    vt.push_back('{1'b1, 5'h0C, 32'hF0, 4'b0001, 32'h0, 1'b0});
    vt.push_back('{1'b0, 5'h0C, 32'h0, 4'b0000, 32'hF0, 1'b0});
    vt.push_back('{1'b0, 5'h08, 32'h0, 4'b0000, 32'h33, 1'b0});
    vt.push_back('{1'b0, 5'h1C, 32'h0, 4'b0000, 32'h0, 1'b1});
    vt.push_back('{1'b0, 5'h02, 32'h0, 4'b0000, 32'h0, 1'b1});
    vt.push_back('{1'b1, 5'h01, 32'hFF, 4'b0001, 32'h0, 1'b1});
    vt.push_back('{1'b1, 5'h1C, 32'hFF, 4'b0001, 32'h0, 1'b1});
    vt.push_back('{1'b0, 5'h00, 32'h0, 4'b0000, 32'hA5, 1'b0});
    vt.push_back('{1'b1, 5'h04, 32'h77, 4'b0001, 32'h0, 1'b0});
    vt.push_back('{1'b0, 5'h04, 32'h0, 4'b0000, 32'h0, 1'b0});
    vt.push_back('{1'b1, 5'h18, 32'h04, 4'b0001, 32'h0, 1'b0});
    vt.push_back('{1'b0, 5'h18, 32'h0, 4'b0000, 32'h04, 1'b0});
    vt.push_back('{1'b1, 5'h00, 32'h12345678, 4'b1111, 32'h0, 1'b0});
    vt.push_back('{1'b0, 5'h00, 32'h0, 4'b0000, 32'h78, 1'b0});
    vt.push_back('{1'b0, 5'h10, 32'h0, 4'b0000, 32'h0, 1'b0});
    repeat (3) @(negedge clk);
    rst = 0; chk_on = 1;
    check("reset uo_out", uo_out, 8'h00);
    check("reset uio_oe", uio_oe, 8'h00);
    check("reset irq", irq, 1'b0);
    check("reset request_ready", bus.request_ready, 1'b1);
    check("reset response_valid", bus.response_valid, 1'b0);
    foreach (vt[i]) begin
      txn(vt[i].w, vt[i].a, vt[i].d, vt[i].s, 0, rd, er);
      check($sformatf("vec%0d read_data", i), rd, vt[i].rd);
      check($sformatf("vec%0d error", i), er, vt[i].er);
    end
    check("strobe uo_out", uo_out, 8'h78);
    ui_in = 8'h3C;
    for (int k = 1; k <= S + 1; k++) begin
      @(negedge clk);
      if (k == S) check("edge not yet irq", irq, 1'b0);
    end
    check("edge latency irq", irq, 1'b1);
    txn(0, 5'h04, 0, 0, 0, rd, er); check("in read", rd, 32'h3C);
    txn(0, 5'h14, 0, 0, 0, rd, er); check("status read", rd, 32'h3C);
    txn(1, 5'h14, 32'h04, 4'b0001, 0, rd, er);
    check("w1c irq", irq, 1'b0);
    txn(0, 5'h14, 0, 0, 0, rd, er); check("status after w1c", rd, 32'h38);
    bus.request_valid = 1; bus.request_write = 0; bus.request_address = 5'h00; bus.response_ready = 0;
    @(negedge clk);
    check("stall response_valid", bus.response_valid, 1'b1);
    held = bus.response_read_data;
    check("stall first data", held, 32'h78);
    bus.request_write = 1; bus.request_write_data = 32'h11; bus.request_strobe = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall valid held", bus.response_valid, 1'b1);
      check("stall ready low", bus.request_ready, 1'b0);
      check("stall data held", bus.response_read_data, 32'h78);
      check("stall no write", uo_out, 8'h78);
    end
    bus.response_ready = 1;
    @(negedge clk);
    check("stall released", bus.response_valid, 1'b0);
    @(negedge clk);
    bus.request_valid = 0;
    check("pending accepted", bus.response_valid, 1'b1);
    check("pending write", uo_out, 8'h11);
    @(negedge clk);
    bus.response_ready = 0;
    ui_in = 8'h00;
    repeat (4) @(negedge clk);
    txn(1, 5'h14, 32'hFF, 4'b0001, 0, rd, er);
    txn(0, 5'h14, 0, 0, 0, rd, er); check("status cleared", rd, 32'h0);
    ui_in = 8'h01;
    repeat (S) @(negedge clk);
    txn(1, 5'h14, 32'h01, 4'b0001, 0, rd, er);
    txn(0, 5'h14, 0, 0, 0, rd, er); check("set beats w1c", rd, 32'h01);
    txn(1, 5'h18, 32'hFF, 4'b0001, 0, rd, er);
    check("irq before reset", irq, 1'b1);
    bus.request_valid = 1; bus.request_write = 0; bus.request_address = 5'h00;
    @(negedge clk);
    bus.request_valid = 0;
    check("pre-reset response", bus.response_valid, 1'b1);
    rst = 1; chk_on = 0; ui_in = 8'h00;
    @(negedge clk);
    check("rst response_valid", bus.response_valid, 1'b0);
    check("rst request_ready", bus.request_ready, 1'b1);
    check("rst uo_out", uo_out, 8'h00);
    check("rst uio_out", uio_out, 8'h00);
    check("rst uio_oe", uio_oe, 8'h00);
    check("rst irq", irq, 1'b0);
    check("rst read_data", bus.response_read_data, 32'h0);
    rst = 0; chk_on = 1;
    txn(0, 5'h14, 0, 0, 0, rd, er); check("rst status", rd, 32'h0);
    txn(0, 5'h18, 0, 0, 0, rd, er); check("rst mask", rd, 32'h0);
    for (int n = 0; n < 300; n++) begin
      logic [4:0] a;
      if ($urandom_range(0, 3) == 0) ui_in = 8'($urandom);
      if ($urandom_range(0, 3) == 0) uio_in = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = $urandom_range(0, 7) == 0 ? 5'($urandom) : {3'($urandom), 2'b00};
      txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
Memory-mapped I/O responder on the cpu data bus. It serves the cpu's load/store requests to a small register file that drives the chip's dedicated and bidirectional pins. Inputs are synchronised and rising edges are recorded with a maskable irq. It sits beside cpu inside tt_um_riscv_cpu_erwanregy and owns ui_in/uo_out/uio_*.

Parameters:
ADDRESS_WIDTH, 5, byte-address bits decoded (register window 0x00-0x1F)
SYNC_STAGES, 2, flop stages on ui_in/uio_in before use (>=2)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
request_valid  input  1  cpu request present
request_ready  output  1  responder can accept a request
request_write  input  1  1=store, 0=load
request_address  input  ADDRESS_WIDTH  byte address
request_write_data  input  32  store data
request_strobe  input  4  byte enables
response_valid  output  1  response present
response_ready  input  1  cpu accepts response
response_read_data  output  32  load data (0 for stores)
response_error  output  1  unmapped or misaligned access
ui_in  input  8  dedicated inputs
uo_out  output  8  dedicated outputs
uio_in  input  8  bidirectional input path
uio_out  output  8  bidirectional output path
uio_oe  output  8  bidirectional enables (1=output)
irq  output  1  |(EDGE_STATUS & EDGE_MASK)

Behaviour:
- One clock; reset synchronous active-high. All state updates on the rising clock edge.
- Reset values: request_ready=1, response_valid=0, response_read_data=0, response_error=0, uo_out=0, uio_out=0, uio_oe=0 (all inputs), EDGE_STATUS=0, EDGE_MASK=0, irq=0, synchroniser flops=0.
- Register map (word aligned, 8-bit data in bits [7:0], upper bits read 0):
  - 0x00 OUT: RW, drives uo_out.
  - 0x04 IN: RO, synchronised ui_in.
  - 0x08 UIO_OUT: RW.
  - 0x0C UIO_OE: RW.
  - 0x10 UIO_IN: RO, synchronised uio_in.
  - 0x14 EDGE_STATUS: write-1-to-clear; a bit sets on a synchronised ui_in 0->1.
  - 0x18 EDGE_MASK: RW.
  - 0x1C: unmapped.
- Handshake:
  - Two states, IDLE and RESPOND.
  - IDLE: request_ready=1. request_valid&request_ready accepts the request, performs the write or captures the read data, then moves to RESPOND.
  - RESPOND: request_ready=0. response_valid=1 and data/error are held stable until response_ready is sampled high, then return to IDLE.
  - Latency is 1 cycle from accept to response_valid. Maximum throughput is one transaction per 2 cycles. Only one transaction is outstanding.
- Write rules:
  - The write occurs only if request_strobe[0]=1. Strobes [3:1] are ignored.
  - Writes to RO registers are silently dropped with error=0.
  - Written values appear on the pins the cycle after accept.
- Error:
  - address[1:0]!=0 or an unmapped address gives error=1, read_data=0, and no side effect.
  - Address bits above ADDRESS_WIDTH are not decoded (aliasing).
- Edge detect:
  - Compares the synchronised value with its 1-cycle-delayed copy. Detection latency from a pin change to EDGE_STATUS set is SYNC_STAGES+1 cycles.
  - A set and a W1C in the same cycle on the same bit: set wins.
- irq is combinational from registered status/mask and is never asserted during reset.
- Reset during RESPOND: the response is dropped (response_valid=0 the next cycle) and all registers return to reset values.

Decomposition:
- Shared package io_bus_package holds:
  - register offset constants OUT_OFFSET..EDGE_MASK_OFFSET;
  - the state enum (IDLE, RESPOND);
  - the response struct {read_data, error}.
- One sub-module, input_synchroniser (WIDTH, STAGES), is instantiated twice for ui_in and uio_in.

Test Plan:
- Reset then idle: uo_out=0x00, uio_oe=0x00, irq=0, request_ready=1, response_valid=0.
- Store 0xA5 to 0x00 with strobe 0b0001: response_valid on the next cycle with error=0. uo_out=0xA5 after accept. With strobe 0b0010 instead, uo_out is unchanged.
- Drive ui_in=0x3C, wait SYNC_STAGES+1 cycles, load 0x04: read_data=0x0000003C. EDGE_STATUS=0x3C. With EDGE_MASK=0x04, irq=1. Write 0x04 to 0x14 and irq=0 with status 0x38.
- Load 0x1C and load 0x02: error=1, read_data=0, and no register changes.
- Hold response_ready=0 for 5 cycles: response stays stable, request_ready=0, and a new request_valid is not accepted until the response is taken.
- Assert reset while in RESPOND: response_valid=0 and all outputs at reset values next cycle. Also cover an edge and a W1C on the same bit in the same cycle: the bit remains 1.
